// File: rtl/kv_pkg.sv
// kv_pkg: shared configuration, widths and types for the KV cache read path.
// Holds the reader geometry, derived field widths, the reader state encoding,
// the response beat payload and the command range check.
package kv_pkg;

  localparam int unsigned DATA_BITS   = 16;
  localparam int unsigned NUM_HEADS   = 4;
  localparam int unsigned HEAD_DIM    = 16;
  localparam int unsigned MAX_SEQ_LEN = 256;
  localparam int unsigned FIFO_DEPTH  = 4;

  localparam int unsigned POS_BITS  = $clog2(MAX_SEQ_LEN);
  localparam int unsigned HEAD_BITS = $clog2(NUM_HEADS);
  localparam int unsigned DIM_BITS  = $clog2(HEAD_DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } kv_rd_state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [POS_BITS-1:0]  pos;
    logic [DIM_BITS-1:0]  dim;
    logic                 last;
  } kv_beat_t;

  // A descending range is only legal as a wrap command; wrap commands skip the length check.
  function automatic logic kv_range_ok(input logic [POS_BITS-1:0] start_pos,
                                       input logic [POS_BITS-1:0] end_pos,
                                       input logic [POS_BITS-1:0] length,
                                       input logic                wrap_en);
    if (start_pos > end_pos) return wrap_en;
    return end_pos < length;
  endfunction

endpackage

// File: rtl/kv_resp_fifo.sv
// kv_resp_fifo: first-word-fall-through FIFO of response beats.
// Ports: clk, reset (async, active-high), flush (sync clear), push/push_beat,
// pop, head_beat (current head), valid (not empty), count (occupancy).
// Push and pop may coincide, including when full.
module kv_resp_fifo
  import kv_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  kv_beat_t         push_beat,
  input  logic             pop,
  output kv_beat_t         head_beat,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  kv_beat_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;

  // Push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop    = pop && valid;
    do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  assign head_beat = mem[rd_ptr];

endmodule

// File: rtl/kv_cache_reader.sv
// kv_cache_reader: read-side initiator for the KV cache.
// Accepts a (head, start..end, K/V) command, issues one element read per cycle
// position-major / dim-minor on the selected cache port, buffers the 1-cycle
// responses in kv_resp_fifo and streams them out over valid/ready.
// Ports: cmd_* command handshake, cache_length, abort, key_read_*/value_read_*
// cache read ports, key_/value_data_in/valid_in responses, out_* stream,
// busy/done/cmd_error status. reset is asynchronous, active-high.
// Build option KV_READER_WRAP_EN: allows start > end as a circular-buffer range.
module kv_cache_reader
  import kv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [HEAD_BITS-1:0] cmd_head,
  input  logic [POS_BITS-1:0]  cmd_start_pos,
  input  logic [POS_BITS-1:0]  cmd_end_pos,
  input  logic                 cmd_sel_value,
  input  logic [POS_BITS-1:0]  cache_length,
  input  logic                 abort,
  output logic                 key_read_en,
  output logic [HEAD_BITS-1:0] key_read_head,
  output logic [POS_BITS-1:0]  key_read_pos,
  output logic [DIM_BITS-1:0]  key_read_dim,
  input  logic [DATA_BITS-1:0] key_data_in,
  input  logic                 key_valid_in,
  output logic                 value_read_en,
  output logic [HEAD_BITS-1:0] value_read_head,
  output logic [POS_BITS-1:0]  value_read_pos,
  output logic [DIM_BITS-1:0]  value_read_dim,
  input  logic [DATA_BITS-1:0] value_data_in,
  input  logic                 value_valid_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [POS_BITS-1:0]  out_pos,
  output logic [DIM_BITS-1:0]  out_dim,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_error
);

`ifdef KV_READER_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CR_W  = CNT_W + 1;
  localparam logic [DIM_BITS-1:0] DIM_MAX = DIM_BITS'(HEAD_DIM - 1);

  kv_rd_state_t         state;
  logic [HEAD_BITS-1:0] head_q;
  logic                 sel_q;
  logic [POS_BITS-1:0]  end_q;
  logic [POS_BITS-1:0]  pos_q;
  logic [DIM_BITS-1:0]  dim_q;
  logic [POS_BITS-1:0]  rd_pos_q;
  logic [DIM_BITS-1:0]  rd_dim_q;
  logic                 rd_last_q;
  logic                 pend_q;
  logic [POS_BITS-1:0]  sh_pos_q;
  logic [DIM_BITS-1:0]  sh_dim_q;
  logic                 sh_last_q;

  logic                 rd_en_any;
  logic                 resp_valid;
  logic                 flush;
  logic                 can_issue;
  logic                 last_read;
  logic                 out_hs;
  logic [CR_W-1:0]      credit_used;
  logic [CNT_W-1:0]     fifo_count;
  kv_beat_t             push_beat;
  kv_beat_t             head_beat;

  // Credit counts the FIFO, the response on the bus now and the read on the bus now,
  // so every accepted read already owns a FIFO slot.
  always_comb begin
    rd_en_any   = key_read_en || value_read_en;
    resp_valid  = pend_q && (sel_q ? value_valid_in : key_valid_in);
    flush       = abort && (state != IDLE);
    credit_used = CR_W'(fifo_count) + CR_W'(pend_q) + CR_W'(rd_en_any);
    can_issue   = credit_used < CR_W'(FIFO_DEPTH);
    last_read   = (pos_q == end_q) && (dim_q == DIM_MAX);
    out_hs      = out_valid && out_ready;
    push_beat   = '{data: (sel_q ? value_data_in : key_data_in),
                    pos:  sh_pos_q,
                    dim:  sh_dim_q,
                    last: sh_last_q};
  end

  // Control FSM, walk counters and the shadow of the read currently on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd_error     <= 1'b0;
      key_read_en   <= 1'b0;
      value_read_en <= 1'b0;
      head_q        <= '0;
      sel_q         <= 1'b0;
      end_q         <= '0;
      pos_q         <= '0;
      dim_q         <= '0;
      rd_pos_q      <= '0;
      rd_dim_q      <= '0;
      rd_last_q     <= 1'b0;
      pend_q        <= 1'b0;
      sh_pos_q      <= '0;
      sh_dim_q      <= '0;
      sh_last_q     <= 1'b0;
    end else begin
      done          <= 1'b0;
      cmd_error     <= 1'b0;
      key_read_en   <= 1'b0;
      value_read_en <= 1'b0;
      pend_q        <= rd_en_any;
      if (rd_en_any) begin
        sh_pos_q  <= rd_pos_q;
        sh_dim_q  <= rd_dim_q;
        sh_last_q <= rd_last_q;
      end
      if (flush) begin
        // Dropping pend_q discards both the returning and the just-issued response.
        state     <= IDLE;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              if (kv_range_ok(cmd_start_pos, cmd_end_pos, cache_length, WRAP_EN)) begin
                head_q    <= cmd_head;
                sel_q     <= cmd_sel_value;
                end_q     <= cmd_end_pos;
                pos_q     <= cmd_start_pos;
                dim_q     <= '0;
                state     <= ISSUE;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end else begin
                cmd_error <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (can_issue) begin
              key_read_en   <= !sel_q;
              value_read_en <= sel_q;
              rd_pos_q      <= pos_q;
              rd_dim_q      <= dim_q;
              rd_last_q     <= last_read;
              if (dim_q == DIM_MAX) begin
                dim_q <= '0;
                pos_q <= pos_q + POS_BITS'(1);
              end else begin
                dim_q <= dim_q + DIM_BITS'(1);
              end
              if (last_read) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (out_hs && out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  kv_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (resp_valid),
    .push_beat (push_beat),
    .pop       (out_ready),
    .head_beat (head_beat),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  assign key_read_head   = head_q;
  assign key_read_pos    = rd_pos_q;
  assign key_read_dim    = rd_dim_q;
  assign value_read_head = head_q;
  assign value_read_pos  = rd_pos_q;
  assign value_read_dim  = rd_dim_q;
  assign out_data        = head_beat.data;
  assign out_pos         = head_beat.pos;
  assign out_dim         = head_beat.dim;
  assign out_last        = head_beat.last;

endmodule

// File: doc/kv_cache_reader.md
Name: kv_cache_reader

Overview:
Read-side initiator for the KV cache. Accepts a command (head, position range, K or V select), walks the range position-major and dim-minor, and issues single-element reads on the cache's key or value read port. It collects the 1-cycle-latency responses into a small FIFO and streams them to the attention datapath over a valid/ready interface. Sits between the attention sequencer and the KV cache.

Parameters:
DATA_BITS, 16, element width (Q1.15)
NUM_HEADS, 4, attention heads
HEAD_DIM, 16, elements per head per position
MAX_SEQ_LEN, 256, cache depth in positions; power of two
FIFO_DEPTH, 4, response buffer entries; power of two, minimum 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_head  in  $clog2(NUM_HEADS)  head select
cmd_start_pos  in  $clog2(MAX_SEQ_LEN)  first position
cmd_end_pos  in  $clog2(MAX_SEQ_LEN)  last position, inclusive
cmd_sel_value  in  1  0 = keys, 1 = values
cache_length  in  $clog2(MAX_SEQ_LEN)  valid length reported by the cache
abort  in  1  synchronous flush
key_read_en / value_read_en  out  1  cache read strobes
key_read_head / value_read_head  out  $clog2(NUM_HEADS)  read head
key_read_pos / value_read_pos  out  $clog2(MAX_SEQ_LEN)  read position
key_read_dim / value_read_dim  out  $clog2(HEAD_DIM)  read dimension
key_data_in / value_data_in  in  DATA_BITS  cache read data
key_valid_in / value_valid_in  in  1  cache read-data valid
out_valid  out  1  stream beat valid
out_ready  in  1  downstream accept
out_data  out  DATA_BITS  element
out_pos  out  $clog2(MAX_SEQ_LEN)  element position
out_dim  out  $clog2(HEAD_DIM)  element dimension
out_last  out  1  final beat of the command
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse on completion
cmd_error  out  1  one-cycle pulse on command rejection

Behaviour:
- Reset: every output is 0 except cmd_ready = 1. FIFO is empty and state is IDLE.
- States:
  - IDLE: cmd_valid && cmd_ready accepts the command.
    - If the range is invalid, pulse cmd_error next cycle, issue no reads, stay in IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: the unselected port's read_en stays 0.
  - DRAIN: entered after the last read is issued. Waits for in-flight data and for the FIFO to empty.
  - DONE: one cycle. done = 1, then IDLE.
- Range is invalid when cmd_start_pos > cmd_end_pos or cmd_end_pos >= cache_length.
- Issue rule: a read is issued in a cycle only if (fifo_count + inflight) < FIFO_DEPTH, where inflight is 0 or 1. No response is ever dropped.
- Read order: dim 0..HEAD_DIM-1 for each position, positions ascending. One read per cycle maximum.
- Cache response: arrives exactly 1 cycle after read_en (cache enable tied high).
  - pos and dim are held in a shadow register and pushed with the data when valid_in = 1.
  - valid_in without a pending read is ignored.
- Total beats per command: (end - start + 1) * HEAD_DIM.
  - out_last is set on the beat with pos = end and dim = HEAD_DIM-1.
  - done is asserted the cycle after that beat handshakes.
- Output is FIFO head, first-word-fall-through.
  - While out_valid = 1 and out_ready = 0, out_* are held stable.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
- Position and dim counters are truncated to their widths; position increments wrap modulo MAX_SEQ_LEN.
- abort (any non-IDLE state): next cycle state = IDLE, FIFO is flushed, and the in-flight response is discarded. No done, no cmd_error. abort in IDLE has no effect.
- Async reset mid-command: immediate return to the reset state. The cache is unaffected.
- cmd_valid while not in IDLE is ignored (cmd_ready = 0).

Optional Feature:
KV_READER_WRAP_EN:
- Defined: a command with cmd_start_pos > cmd_end_pos is legal (sliding-window circular buffer).
  - Traversal is start..MAX_SEQ_LEN-1, then 0..end.
  - Beat count = (end - start + MAX_SEQ_LEN + 1) mod MAX_SEQ_LEN, multiplied by HEAD_DIM, where 0 means MAX_SEQ_LEN.
  - The cache_length check is skipped for wrap commands only.
- Undefined: start > end raises cmd_error as above.

Decomposition:
- Package kv_pkg holds:
  - localparams POS_BITS, HEAD_BITS, DIM_BITS (the $clog2 widths);
  - state typedef kv_rd_state_t {IDLE, ISSUE, DRAIN, DONE};
  - beat struct typedef {data, pos, dim, last}.
- One sub-module, kv_resp_fifo: parameterized synchronous FIFO of beat structs with async reset, flush, count, and simultaneous push/pop. The top module holds the FSM, counters, shadow register and credit check.

Test Plan:
- cache_length = 8, head 2, K, positions 3..4, out_ready = 1 -> 32 beats in order (3,0)..(4,15); data matches preloaded key_cache[h2]; out_last only on (4,15); done 1 cycle later; value_read_en never asserted.
- Same command with cmd_sel_value = 1 and out_ready toggling 1-of-3 cycles -> identical ordered values; no beat lost or duplicated; out_* stable while stalled; read_en never issued when fifo_count + inflight = 4.
- start = 5, end = 2 (macro undefined), or end = 8 with cache_length = 8 -> cmd_error pulse; no read_en; cmd_ready back high.
- abort asserted after 6 beats, with out_ready = 0 and the FIFO full -> next cycle busy = 0, out_valid = 0, no done; a new command then runs cleanly from beat 0.
- KV_READER_WRAP_EN, MAX_SEQ_LEN = 256, start = 254, end = 1 -> 64 beats, positions 254, 255, 0, 1; done asserted.
- Async reset mid-ISSUE -> all outputs at reset values immediately, independent of clk.
